// File: rtl/axis_injection_arbiter.sv
// rtl/axis_injection_arbiter.sv - packet-granular round-robin AXIS injection arbiter
module axis_injection_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 2,
    parameter int GRANT_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    s_axis_tvalid,
    output logic [NUM_REQ-1:0]                    s_axis_tready,
    input  logic [NUM_REQ-1:0][TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_REQ-1:0]                    s_axis_tlast,
    input  logic [NUM_REQ-1:0][TID_WIDTH-1:0]     s_axis_tid,
    input  logic [NUM_REQ-1:0][TDEST_WIDTH-1:0]   s_axis_tdest,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [TDATA_WIDTH-1:0]                m_axis_tdata,
    output logic                                  m_axis_tlast,
    output logic [TID_WIDTH-1:0]                  m_axis_tid,
    output logic [TDEST_WIDTH-1:0]                m_axis_tdest,
    output logic                                  grant_valid,
    output logic [GRANT_WIDTH-1:0]                grant_id
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [GRANT_WIDTH-1:0] grant_id_nxt;
    logic [GRANT_WIDTH-1:0] pick;
    logic                   any_valid;
    logic                   slave_ready;
    logic                   accept;
    logic                   out_full;

    // Round-robin search: first valid requester after the most recent grantee, with wrap.
    always_comb begin
        pick      = grant_id;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            logic [GRANT_WIDTH-1:0] idx;
            idx = GRANT_WIDTH'((int'(grant_id) + i) % NUM_REQ);
            if (!any_valid && s_axis_tvalid[idx]) begin
                any_valid = 1'b1;
                pick      = idx;
            end
        end
    end

    // Next state, grantee ready and beat acceptance; the grant is frozen until tlast is taken.
    always_comb begin
        state_nxt     = state;
        grant_id_nxt  = grant_id;
        s_axis_tready = '0;
        accept        = 1'b0;
        slave_ready   = !out_full || m_axis_tready;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt    = LOCKED;
                    grant_id_nxt = pick;
                end
            end
            LOCKED: begin
                s_axis_tready[grant_id] = slave_ready;
                accept                  = s_axis_tvalid[grant_id] && slave_ready;
                if (accept && s_axis_tlast[grant_id]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and grant registers; reset makes requester 0 the first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= GRANT_WIDTH'(NUM_REQ - 1);
        end else begin
            state    <= state_nxt;
            grant_id <= grant_id_nxt;
        end
    end

    // One-entry output register: load on accept, drain when the router takes the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_full     <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
            m_axis_tid   <= '0;
            m_axis_tdest <= '0;
        end else if (accept) begin
            out_full     <= 1'b1;
            m_axis_tdata <= s_axis_tdata[grant_id];
            m_axis_tlast <= s_axis_tlast[grant_id];
            m_axis_tid   <= s_axis_tid[grant_id];
            m_axis_tdest <= s_axis_tdest[grant_id];
        end else if (out_full && m_axis_tready) begin
            out_full <= 1'b0;
        end
    end

    assign m_axis_tvalid = out_full;
    assign grant_valid   = (state == LOCKED);

endmodule

// File: tb/tb_axis_injection_arbiter.sv
// tb/tb_axis_injection_arbiter.sv - directed self-checking bench for axis_injection_arbiter
module tb_axis_injection_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int IW  = 2;
    localparam int DEW = 2;
    localparam int GW  = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            s_axis_tvalid;
    logic [N-1:0]            s_axis_tready;
    logic [N-1:0][DW-1:0]    s_axis_tdata;
    logic [N-1:0]            s_axis_tlast;
    logic [N-1:0][IW-1:0]    s_axis_tid;
    logic [N-1:0][DEW-1:0]   s_axis_tdest;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic [DW-1:0]           m_axis_tdata;
    logic                    m_axis_tlast;
    logic [IW-1:0]           m_axis_tid;
    logic [DEW-1:0]          m_axis_tdest;
    logic                    grant_valid;
    logic [GW-1:0]           grant_id;

    axis_injection_arbiter #(
        .NUM_REQ(N), .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DEW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [DW:0]     src_q [N][$];
    logic [DW-1:0]   out_data [$];
    logic            out_last [$];
    logic [IW-1:0]   out_tid [$];
    logic [DEW-1:0]  out_tdest [$];
    int              out_cyc [$];
    int              in_cyc [$];
    int              grants [$];
    int              lock_len [$];
    int              cur_len;
    int              ready_viol;
    logic            prev_gv;
    logic [N-1:0]    hs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_srcs();
        logic [DW:0] b;
        for (int r = 0; r < N; r++) begin
            s_axis_tid[r]   = IW'(r);
            s_axis_tdest[r] = DEW'(N - 1 - r);
            if (src_q[r].size() > 0) begin
                b                = src_q[r][0];
                s_axis_tvalid[r] = 1'b1;
                s_axis_tdata[r]  = b[DW-1:0];
                s_axis_tlast[r]  = b[DW];
            end else begin
                s_axis_tvalid[r] = 1'b0;
                s_axis_tdata[r]  = '0;
                s_axis_tlast[r]  = 1'b0;
            end
        end
    endtask

    task automatic push_pkt(input int r, input logic [DW-1:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            src_q[r].push_back({(k == len - 1), base + DW'(k)});
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle++;
        for (int r = 0; r < N; r++) hs[r] = s_axis_tvalid[r] && s_axis_tready[r];
        if (|hs) in_cyc.push_back(cycle);
        if (s_axis_tready != '0 && (!grant_valid || s_axis_tready != (N'(1) << grant_id)))
            ready_viol++;
        if (m_axis_tvalid && m_axis_tready) begin
            out_data.push_back(m_axis_tdata);
            out_last.push_back(m_axis_tlast);
            out_tid.push_back(m_axis_tid);
            out_tdest.push_back(m_axis_tdest);
            out_cyc.push_back(cycle);
        end
        if (grant_valid && !prev_gv) grants.push_back(int'(grant_id));
        if (grant_valid) cur_len++;
        else if (prev_gv) begin
            lock_len.push_back(cur_len);
            cur_len = 0;
        end
        prev_gv = grant_valid;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) if (hs[r]) void'(src_q[r].pop_front());
        drive_srcs();
    endtask

    task automatic clear_logs();
        out_data.delete(); out_last.delete(); out_tid.delete(); out_tdest.delete();
        out_cyc.delete(); in_cyc.delete(); grants.delete(); lock_len.delete();
        cur_len = 0; ready_viol = 0; prev_gv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int r = 0; r < N; r++) src_q[r].delete();
        drive_srcs();
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic run_until_out(input int n, input int budget);
        int c = 0;
        while (out_data.size() < n && c < budget) begin
            step();
            c++;
        end
        chk("beat_count", out_data.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] held;
        int unstable, rdy_hi, n;
        int exp_r[5];
        logic [DW-1:0] exp_b[5];
        logic [DW-1:0] exp_seq[8];

        // reset state
        do_reset();
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_grant_id", grant_id, 3);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);

        // requester 0, three beats
        push_pkt(0, 'hA0, 3);
        drive_srcs();
        step();
        chk("t1_grant_valid", grant_valid, 1);
        chk("t1_grant_id", grant_id, 0);
        run_until_out(3, 20);
        for (int i = 0; i < 3; i++) begin
            chk("t1_data", out_data[i], 'hA0 + i);
            chk("t1_last", out_last[i], (i == 2));
        end
        chk("t1_latency", out_cyc[0] - in_cyc[0], 1);
        chk("t1_back_to_back", out_cyc[2] - out_cyc[0], 2);
        chk("t1_idle_after", grant_valid, 0);
        chk("t1_ready_viol", ready_viol, 0);

        // all four requesters busy with 2-beat packets
        do_reset();
        push_pkt(0, 'h00, 2);
        push_pkt(0, 'h04, 2);
        push_pkt(1, 'h10, 2);
        push_pkt(2, 'h20, 2);
        push_pkt(3, 'h30, 2);
        drive_srcs();
        run_until_out(10, 60);
        exp_r = '{0, 1, 2, 3, 0};
        exp_b = '{'h00, 'h10, 'h20, 'h30, 'h04};
        chk("t2_grant_count", grants.size(), 5);
        for (int p = 0; p < 5; p++) begin
            chk("t2_grant", grants[p], exp_r[p]);
            for (int b = 0; b < 2; b++) begin
                chk("t2_data", out_data[2*p+b], exp_b[p] + b);
                chk("t2_tid", out_tid[2*p+b], exp_r[p]);
                chk("t2_tdest", out_tdest[2*p+b], 3 - exp_r[p]);
                chk("t2_last", out_last[2*p+b], b);
            end
            if (p > 0) chk("t2_bubble", out_cyc[2*p] - out_cyc[2*p-2], 3);
        end
        chk("t2_ready_viol", ready_viol, 0);

        // grantee 2 holds the lock while 1 and 3 wait
        do_reset();
        push_pkt(2, 'h40, 4);
        drive_srcs();
        step();
        push_pkt(1, 'h50, 2);
        push_pkt(3, 'h60, 2);
        drive_srcs();
        run_until_out(8, 50);
        exp_seq = '{'h40, 'h41, 'h42, 'h43, 'h60, 'h61, 'h50, 'h51};
        chk("t3_grant0", grants[0], 2);
        chk("t3_grant1", grants[1], 3);
        chk("t3_grant2", grants[2], 1);
        for (int i = 0; i < 8; i++) chk("t3_order", out_data[i], exp_seq[i]);
        chk("t3_ready_viol", ready_viol, 0);

        do_reset();
        push_pkt(2, 'h70, 2);
        drive_srcs();
        step();
        push_pkt(1, 'h78, 2);
        drive_srcs();
        run_until_out(4, 30);
        chk("t3b_grant0", grants[0], 2);
        chk("t3b_wrap", grants[1], 1);

        // backpressure for five cycles mid-packet
        do_reset();
        push_pkt(0, 'h80, 6);
        drive_srcs();
        run_until_out(2, 20);
        m_axis_tready = 1'b0;
        step();
        held = m_axis_tdata;
        unstable = 0;
        rdy_hi = 0;
        repeat (5) begin
            step();
            if (!m_axis_tvalid || m_axis_tdata !== held) unstable++;
            if (s_axis_tready != '0) rdy_hi++;
        end
        chk("t4_payload_stable", unstable, 0);
        chk("t4_ready_low", rdy_hi, 0);
        chk("t4_held_beat", held, 'h82);
        n = out_data.size();
        chk("t4_no_drain", n, 2);
        m_axis_tready = 1'b1;
        run_until_out(6, 30);
        for (int i = 0; i < 6; i++) chk("t4_data", out_data[i], 'h80 + i);
        chk("t4_resume_rate", out_cyc[5] - out_cyc[2], 3);

        // single-beat packets from 1 and 3
        do_reset();
        push_pkt(1, 'h91, 1);
        push_pkt(3, 'h93, 1);
        drive_srcs();
        run_until_out(2, 20);
        step();
        step();
        chk("t5_grant0", grants[0], 1);
        chk("t5_grant1", grants[1], 3);
        chk("t5_lock_len0", lock_len[0], 1);
        chk("t5_lock_len1", lock_len[1], 1);
        chk("t5_data0", out_data[0], 'h91);
        chk("t5_data1", out_data[1], 'h93);
        chk("t5_last", {out_last[0], out_last[1]}, 2'b11);

        // reset during beat 2 of a 4-beat packet
        do_reset();
        push_pkt(2, 'hB0, 4);
        drive_srcs();
        n = 0;
        while (in_cyc.size() < 1 && n < 20) begin
            step();
            n++;
        end
        chk("t6_started", m_axis_tvalid, 1);
        rst = 1'b1;
        #1;
        chk("t6_m_tvalid", m_axis_tvalid, 0);
        chk("t6_grant_valid", grant_valid, 0);
        chk("t6_s_tready", s_axis_tready, 0);
        chk("t6_grant_id", grant_id, 3);
        for (int r = 0; r < N; r++) src_q[r].delete();
        drive_srcs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        push_pkt(3, 'hC3, 1);
        push_pkt(0, 'hC0, 1);
        drive_srcs();
        run_until_out(2, 20);
        chk("t6_first_grant", grants[0], 0);
        chk("t6_first_data", out_data[0], 'hC0);
        chk("t6_second_data", out_data[1], 'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_injection_arbiter.md
Name: axis_injection_arbiter

Overview:
- Packet-granular round-robin arbiter that shares a single router injection AXI-Stream port between NUM_REQ user requesters.
- Sits in the user clock domain in front of the serializer shim input of a router tile.
- Once a requester is granted, the grant is held until that requester's tlast beat is accepted, so packets are never interleaved.
- Output is registered through a one-entry pipeline register.

Parameters:
- NUM_REQ, 4, number of requesting AXIS sources (2..16).
- TDATA_WIDTH, 64, data width of every stream.
- TID_WIDTH, 2, tid width of every stream.
- TDEST_WIDTH, 2, tdest width of every stream.
- GRANT_WIDTH, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  block clock.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_tvalid  in  [NUM_REQ]  per-requester valid.
- s_axis_tready  out  [NUM_REQ]  per-requester ready.
- s_axis_tdata  in  [NUM_REQ][TDATA_WIDTH]  per-requester data.
- s_axis_tlast  in  [NUM_REQ]  per-requester end of packet.
- s_axis_tid  in  [NUM_REQ][TID_WIDTH]  per-requester tid.
- s_axis_tdest  in  [NUM_REQ][TDEST_WIDTH]  per-requester tdest.
- m_axis_tvalid  out  1  to router injection port.
- m_axis_tready  in  1  from router injection port.
- m_axis_tdata  out  TDATA_WIDTH  muxed data.
- m_axis_tlast  out  1  muxed tlast.
- m_axis_tid  out  TID_WIDTH  muxed tid.
- m_axis_tdest  out  TDEST_WIDTH  muxed tdest.
- grant_valid  out  1  high while state is LOCKED.
- grant_id  out  GRANT_WIDTH  index of the current or most recent grantee.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, grant_id=NUM_REQ-1 (so requester 0 has first priority), grant_valid=0, out_full=0, m_axis_tvalid=0, m_axis_t* data fields=0, all s_axis_tready=0.
- FSM IDLE:
  - If any s_axis_tvalid is high, select the first requester r with tvalid=1, searching from (grant_id+1) mod NUM_REQ upward with wrap.
  - Next cycle: grant_id=r, state=LOCKED.
  - If no requester is valid, stay in IDLE; grant_id is unchanged.
  - In IDLE, all s_axis_tready=0.
- FSM LOCKED:
  - s_axis_tready[grant_id] = (!out_full || m_axis_tready). All other readies are 0.
  - Accepting a beat (tvalid && tready on the grantee) loads the output register and sets out_full=1.
  - If the accepted beat has tlast=1, next state is IDLE.
  - grant_id is not re-evaluated while LOCKED.
- Output register:
  - m_axis_tvalid = out_full.
  - out_full clears on (m_axis_tvalid && m_axis_tready) when no new beat is loaded that cycle.
  - A simultaneous drain and load keeps out_full=1 with the new beat.
  - Output data changes only on a load.
- Latency and throughput:
  - Accepted beat appears on m_axis one cycle later.
  - One beat/cycle sustained within a packet while m_axis_tready=1.
  - One arbitration bubble cycle between packets (the IDLE cycle).
  - Arbitration in IDLE proceeds even while out_full holds the previous tail beat.
- Fairness: a requester that stays valid is granted within NUM_REQ packets.
- Backpressure: m_axis_tready=0 with out_full=1 drops grantee ready to 0. Master payload is held stable until accepted (AXIS rule).
- Protocol assumption: a requester deasserting tvalid mid-packet while granted keeps the lock (no timeout). Requesters must not drop tvalid before tready.
- Single-beat packets: tlast on the first beat returns to IDLE after exactly one LOCKED cycle.
- Reset mid-packet: all state is cleared immediately. Any partial packet in the output register is discarded (m_axis_tvalid=0 asynchronously).

Test Plan:
- Reset, then requester 0 sends a 3-beat packet (data 0xA0..0xA2), m_axis_tready=1 -> grant_id=0 one cycle after tvalid. Beats appear on m_axis on consecutive cycles, 1 cycle after acceptance. m_axis_tlast=1 on 0xA2. State returns to IDLE.
- All 4 requesters continuously valid with 2-beat packets -> grant order 0,1,2,3,0. One IDLE bubble between packets. No interleaving of tid/tdest within a packet.
- Grantee 2 mid-packet while requester 1 asserts valid -> requester 1 ready stays 0 until requester 2's tlast is accepted. Next grant is 3 if valid, else wraps to 1.
- m_axis_tready held 0 for 5 cycles with out_full=1 -> grantee ready=0 and m_axis payload stable. On release, one beat per cycle resumes with no loss or duplication.
- Single-beat packets (tlast=1) from requesters 1 and 3 -> grants 1 then 3. Each LOCKED state lasts 1 cycle.
- Assert rst during beat 2 of a 4-beat packet -> m_axis_tvalid=0, grant_valid=0, all tready=0 immediately. After release, requester 0 has first priority.
